// File: rtl/press_pkg.sv
// Shared types and default timing constants for the button press classifier.
package press_pkg;

    // Roughly 1 s long-press and 0.5 s double-click window at 50 MHz
    localparam int unsigned LONG_CYCLES_DEF = 50_000_000;
    localparam int unsigned GAP_CYCLES_DEF  = 25_000_000;

    typedef enum logic [2:0] {
        WAIT_REL,
        IDLE,
        PRESS,
        GAP,
        LONG,
        DRAIN
    } state_t;

    // Larger of two thresholds; sizes the shared counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies a debounced button level into short, long and double-click events.
// One shared counter tracks either the high run (PRESS) or the low run (GAP).
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic held
);

    localparam int unsigned CNT_MAX = max_u(LONG_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Classifier FSM with shared run counter and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WAIT_REL;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;

            case (state)
                // A press already in progress at reset is discarded
                WAIT_REL: begin
                    if (!button) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (button) begin
                        state <= PRESS;
                        cnt   <= CNT_ONE;
                    end
                end

                PRESS: begin
                    if (button) begin
                        if (cnt == LONG_LAST) begin
                            state      <= LONG;
                            cnt        <= '0;
                            long_pulse <= 1'b1;
                            held       <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= GAP;
                        cnt   <= CNT_ONE;
                    end
                end

                // A press on the final gap sample still counts as a double click
                GAP: begin
                    if (button) begin
                        state        <= DRAIN;
                        cnt          <= '0;
                        double_pulse <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        short_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                LONG: begin
                    if (!button) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                end

                // Second click of a double: wait for release, never long
                DRAIN: begin
                    if (!button) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= WAIT_REL;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Directed table plus random-stream check of press_classifier (LONG=8, GAP=4).
module tb_press_classifier;

    localparam int unsigned LONG = 8;
    localparam int unsigned GAP  = 4;

    logic clk;
    logic rst_n;
    logic button;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic held;

    int checks;
    int errors;

    press_classifier #(
        .LONG_CYCLES(LONG),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse),
        .held        (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row: inputs held for reps cycles, expected {short,long,double,held} after each
    typedef struct {
        logic        rst_n;
        logic        button;
        int unsigned reps;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input int unsigned n, input logic [3:0] e);
        vec_t v;
        v.rst_n  = r;
        v.button = b;
        v.reps   = n;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst_n  = r;
        button = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {short_pulse, long_pulse, double_pulse, held};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {s,l,d,h}=%b expected %b", name, act, exp);
        end
    endtask

    // Run-length reference model of the expected output sequence
    bit          m_armed;
    int unsigned m_hi;
    int unsigned m_lo;
    bit          m_short_pend;
    bit          m_second;
    bit          m_long_held;

    task automatic model_step(input logic r, input logic b, output logic [3:0] e);
        logic es, el, ed;
        es = 1'b0; el = 1'b0; ed = 1'b0;
        if (!r) begin
            m_armed = 0; m_hi = 0; m_lo = 0;
            m_short_pend = 0; m_second = 0; m_long_held = 0;
        end else if (!m_armed) begin
            if (!b) m_armed = 1;
        end else if (b) begin
            m_lo = 0;
            if (m_hi < LONG) m_hi++;
            if (m_short_pend) begin
                m_short_pend = 0;
                m_second = 1;
                ed = 1'b1;
            end else if (!m_second && !m_long_held && m_hi == LONG) begin
                m_long_held = 1;
                el = 1'b1;
            end
        end else begin
            if (m_long_held) m_long_held = 0;
            else if (m_second) m_second = 0;
            else if (m_hi > 0) begin
                m_short_pend = 1;
                m_lo = 1;
            end else if (m_short_pend) begin
                m_lo++;
                if (m_lo == GAP) begin
                    es = 1'b1;
                    m_short_pend = 0;
                end
            end
            m_hi = 0;
        end
        e = {es, el, ed, m_long_held};
    endtask

    initial begin
        int idx;
        logic [3:0] e;
        logic lvl;
        int unsigned run_left;
        int dut_s, dut_l, dut_d, mod_s, mod_l, mod_d;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        button = 1'b0;

        // Reset state, and a press already in progress at reset is ignored
        add(0, 0, 2, 4'b0000);
        add(0, 1, 1, 4'b0000);
        add(1, 1, 3, 4'b0000);
        add(1, 0, 1, 4'b0000);
        // Short: high 3, low 6 -> short after 4th low
        add(1, 1, 3, 4'b0000);
        add(1, 0, 3, 4'b0000);
        add(1, 0, 1, 4'b1000);
        add(1, 0, 2, 4'b0000);
        // Long: high 12 -> long after 8th high, held until after first low
        add(1, 1, 7, 4'b0000);
        add(1, 1, 1, 4'b0101);
        add(1, 1, 4, 4'b0001);
        add(1, 0, 1, 4'b0000);
        add(1, 0, 3, 4'b0000);
        // Double: high 3, low 2, high 10, low
        add(1, 1, 3, 4'b0000);
        add(1, 0, 2, 4'b0000);
        add(1, 1, 1, 4'b0010);
        add(1, 1, 9, 4'b0000);
        add(1, 0, 5, 4'b0000);
        // Press wins over gap timeout on the last gap sample
        add(1, 1, 3, 4'b0000);
        add(1, 0, 3, 4'b0000);
        add(1, 1, 1, 4'b0010);
        add(1, 1, 2, 4'b0000);
        add(1, 0, 2, 4'b0000);
        // Reset during LONG with button held, then a fresh short press
        add(1, 1, 7, 4'b0000);
        add(1, 1, 1, 4'b0101);
        add(1, 1, 2, 4'b0001);
        add(0, 1, 1, 4'b0000);
        add(1, 1, 12, 4'b0000);
        add(1, 0, 1, 4'b0000);
        add(1, 1, 3, 4'b0000);
        add(1, 0, 3, 4'b0000);
        add(1, 0, 1, 4'b1000);
        // Reset mid-gap drops the pending short
        add(1, 1, 3, 4'b0000);
        add(1, 0, 2, 4'b0000);
        add(0, 0, 1, 4'b0000);
        add(1, 0, 6, 4'b0000);

        idx = 0;
        foreach (vecs[i]) begin
            for (int k = 0; k < int'(vecs[i].reps); k++) begin
                step(vecs[i].rst_n, vecs[i].button);
                check($sformatf("vec%0d.%0d", i, k), outs(), vecs[i].exp);
                idx++;
            end
        end

        // Random run-length stream against the reference model
        step(0, 0);
        model_step(0, 0, e);
        check("rand_reset", outs(), e);
        lvl = 1'b0;
        run_left = 0;
        dut_s = 0; dut_l = 0; dut_d = 0;
        mod_s = 0; mod_l = 0; mod_d = 0;
        for (int c = 0; c < 10000; c++) begin
            logic r;
            if (run_left == 0) begin
                lvl = ~lvl;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            r = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step(r, lvl);
            model_step(r, lvl, e);
            check($sformatf("rand%0d", c), outs(), e);
            checks++;
            if ($countones({short_pulse, long_pulse, double_pulse}) > 1) begin
                errors++;
                $display("FAIL onehot%0d: got strobes %b required at most one high",
                         c, {short_pulse, long_pulse, double_pulse});
            end
            dut_s += int'(short_pulse);
            dut_l += int'(long_pulse);
            dut_d += int'(double_pulse);
            mod_s += int'(e[3]);
            mod_l += int'(e[2]);
            mod_d += int'(e[1]);
        end

        checks++;
        if (dut_s != mod_s || dut_l != mod_l || dut_d != mod_d) begin
            errors++;
            $display("FAIL event_counts: got s=%0d l=%0d d=%0d expected s=%0d l=%0d d=%0d",
                     dut_s, dut_l, dut_d, mod_s, mod_l, mod_d);
        end
        checks++;
        if (mod_s == 0 || mod_l == 0 || mod_d == 0) begin
            errors++;
            $display("FAIL rand_coverage: got model s=%0d l=%0d d=%0d expected all nonzero",
                     mod_s, mod_l, mod_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
